axis_realign_gen: RTL

- Parametrised successor to the 32-bit byte realigner.
- Takes an AXI4-Stream packet whose beats carry contiguous byte runs and repacks them into dense output beats.
- Optionally prefixes the packet with a per-packet offset of null (tkeep=0) lanes.
- Generalised to DATA_BYTES lanes, with a built-in synchronous FWFT output FIFO (replaces the async FIFO instance) and a non-contiguous-tkeep error flag. Sits between DMA/packet engines and byte-addressed sinks.

---
 rtl/axis_realign_gen.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_realign_gen.sv
// axis_realign_gen: repacks AXI4-Stream byte runs into dense beats behind a sync FWFT FIFO,
// with an optional null-lane prefix per packet. Define AXIS_REALIGN_GEN_STATS_EN for packet/byte counters.
module axis_realign_gen #(
    parameter int    DATA_BYTES        = 4,
    parameter string INPUT_BIG_ENDIAN  = "TRUE",
    parameter string OUTPUT_BIG_ENDIAN = "TRUE",
    parameter int    FIFO_ALOG2        = 4,
    localparam int   OW                = $clog2(DATA_BYTES)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [8*DATA_BYTES-1:0] s_tdata,
    input  logic [DATA_BYTES-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    input  logic [OW-1:0]           s_tuser,
    output logic                    s_tready,
    output logic [8*DATA_BYTES-1:0] m_tdata,
    output logic [DATA_BYTES-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    err_keep
`ifdef AXIS_REALIGN_GEN_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [31:0]             stat_pkts,
    output logic [31:0]             stat_bytes
`endif
);
    localparam int DB     = DATA_BYTES;
    localparam int NS     = 2*DB-1;
    localparam int BW     = OW+1;
    localparam int DEPTH  = 2**FIFO_ALOG2;
    localparam int CW     = FIFO_ALOG2+1;
    localparam int FW     = 8*DB+DB+1;
    localparam bit IN_BE  = (INPUT_BIG_ENDIAN == "TRUE");
    localparam bit OUT_BE = (OUTPUT_BIG_ENDIAN == "TRUE");

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t             state_q, state_d;
    logic [BW-1:0]      b_q, b_d;
    logic [NS-1:0][7:0] dat_q, dat_d;
    logic [NS-1:0]      kp_q, kp_d;

    logic [DB-1:0][7:0] ln_dat, sh_dat;
    logic [DB-1:0]      ln_kp;
    logic [OW-1:0]      lo, hi;
    logic [BW-1:0]      pc, span, b0, b_post;
    logic               any_kp, accept;
    logic [NS-1:0][7:0] ins_dat, acc_dat;
    logic [NS-1:0]      base_kp, acc_kp;

    logic               wr_en, wr_last, rd_en, full_q;
    logic [DB-1:0][7:0] wr_dat;
    logic [DB-1:0]      wr_kp;

    always_comb begin
        for (int k = 0; k < DB; k++) begin
            ln_dat[k] = IN_BE ? s_tdata[8*(DB-1-k) +: 8] : s_tdata[8*k +: 8];
            ln_kp[k]  = IN_BE ? s_tkeep[DB-1-k] : s_tkeep[k];
        end
    end

    // A non-contiguous keep is treated as the full run from lowest to highest set lane.
    always_comb begin
        lo = '0;
        hi = '0;
        pc = '0;
        for (int k = DB-1; k >= 0; k--) if (ln_kp[k]) lo = OW'(k);
        for (int k = 0; k < DB; k++) begin
            if (ln_kp[k]) begin
                hi = OW'(k);
                pc = pc + BW'(1);
            end
        end
    end

    assign any_kp   = |ln_kp;
    assign span     = any_kp ? BW'(hi) - BW'(lo) + BW'(1) : '0;
    assign err_keep = accept && (pc != span);

    assign sh_dat  = ln_dat >> {lo, 3'b000};
    assign b0      = (state_q == IDLE) ? BW'(s_tuser) : b_q;
    assign base_kp = (state_q == IDLE) ? '0 : kp_q;
    assign ins_dat = {{(8*(NS-DB)){1'b0}}, sh_dat} << {b0, 3'b000};
    assign b_post  = b0 + span;

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            if (BW'(i) >= b0 && BW'(i) < b_post) begin
                acc_dat[i] = ins_dat[i];
                acc_kp[i]  = 1'b1;
            end else begin
                acc_dat[i] = dat_q[i];
                acc_kp[i]  = (BW'(i) < b0) ? base_kp[i] : 1'b0;
            end
        end
    end

    assign s_tready = aresetn && (state_q != FLUSH) && !full_q;
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        dat_d   = dat_q;
        kp_d    = kp_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_dat  = acc_dat[DB-1:0];
        wr_kp   = acc_kp[DB-1:0];
        case (state_q)
            IDLE, RUN: if (accept) begin
                state_d = RUN;
                b_d     = b_post;
                dat_d   = acc_dat;
                kp_d    = acc_kp;
                if (s_tlast && b_post <= BW'(DB)) begin
                    wr_en   = 1'b1;
                    wr_last = 1'b1;
                    state_d = IDLE;
                    b_d     = '0;
                    kp_d    = '0;
                end else if (b_post >= BW'(DB)) begin
                    wr_en   = 1'b1;
                    b_d     = b_post - BW'(DB);
                    dat_d   = acc_dat >> (8*DB);
                    kp_d    = acc_kp >> DB;
                    if (s_tlast) state_d = FLUSH;
                end
            end
            FLUSH: if (!full_q) begin
                wr_en   = 1'b1;
                wr_last = 1'b1;
                wr_dat  = dat_q[DB-1:0];
                wr_kp   = kp_q[DB-1:0];
                state_d = IDLE;
                b_d     = '0;
                kp_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            b_q     <= '0;
            kp_q    <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            kp_q    <= kp_d;
        end
    end

    always_ff @(posedge aclk) dat_q <= dat_d;

    // FWFT FIFO; full is registered so a same-cycle read never admits a write.
    logic [FW-1:0]         mem [DEPTH];
    logic [FIFO_ALOG2-1:0] wp_q, rp_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FW-1:0]         rd_word;

    assign m_tvalid = (cnt_q != '0);
    assign rd_en    = m_tvalid && m_tready;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !rd_en) cnt_d = cnt_q + CW'(1);
        else if (!wr_en && rd_en) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en) wp_q <= wp_q + FIFO_ALOG2'(1);
            if (rd_en) rp_q <= rp_q + FIFO_ALOG2'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge aclk) if (wr_en) mem[wp_q] <= {wr_last, wr_kp, wr_dat};

    assign rd_word = mem[rp_q];

    always_comb begin
        m_tdata = '0;
        m_tkeep = '0;
        m_tlast = rd_word[FW-1];
        for (int k = 0; k < DB; k++) begin
            if (OUT_BE) begin
                m_tdata[8*(DB-1-k) +: 8] = rd_word[8*k +: 8];
                m_tkeep[DB-1-k]          = rd_word[8*DB+k];
            end else begin
                m_tdata[8*k +: 8] = rd_word[8*k +: 8];
                m_tkeep[k]        = rd_word[8*DB+k];
            end
        end
    end

`ifdef AXIS_REALIGN_GEN_STATS_EN
    logic [31:0]   pk_q, by_q;
    logic [BW-1:0] wr_cnt;
    logic [32:0]   by_sum;

    always_comb begin
        wr_cnt = '0;
        for (int k = 0; k < DB; k++) if (wr_kp[k]) wr_cnt = wr_cnt + BW'(1);
    end

    assign by_sum = {1'b0, by_q} + 33'(wr_cnt);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pk_q <= '0;
            by_q <= '0;
        end else if (stat_clr) begin
            pk_q <= '0;
            by_q <= '0;
        end else if (wr_en) begin
            if (wr_last && pk_q != '1) pk_q <= pk_q + 32'd1;
            by_q <= by_sum[32] ? '1 : by_sum[31:0];
        end
    end

    assign stat_pkts  = pk_q;
    assign stat_bytes = by_q;
`endif
endmodule
